strokie_issue_ctrl: RTL and testbench

//   Upstream issue/collect stage for strokie_alu. Accepts one FP operation per

---
 rtl/strokie_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_strokie_issue_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/strokie_issue_ctrl.sv
// Issue/collect controller for strokie_alu: accepts one op, holds operands through a
// settle window, waits for ALU ready or a timeout, then hands the result downstream.
module strokie_issue_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int TIMEOUT    = 16,
   parameter int ERRW       = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [1:0]      in_op,
   input  logic            in_mode_fp,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [1:0]      alu_op,
   output logic            alu_mode_fp,
   input  logic [31:0]     alu_q,
   input  logic            alu_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_q,
   output logic            out_err,
   output logic            busy,
   output logic [ERRW-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_DONE} state_t;

   localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]   WAIT_LAST   = CW'(TIMEOUT - 1);
   localparam logic [ERRW-1:0] ERR_MAX     = {ERRW{1'b1}};

   // FP16 values travel in the ALU's upper halfword.
   function automatic logic [31:0] pack_operand(input logic mode_fp, input logic [31:0] x);
      return mode_fp ? x : {x[15:0], 16'h0000};
   endfunction

   function automatic logic [31:0] unpack_result(input logic mode_fp, input logic [31:0] q);
      return mode_fp ? q : {16'h0000, q[31:16]};
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]      alu_op_q, alu_op_d;
   logic            alu_mode_q, alu_mode_d;
   logic [31:0]     out_q_q, out_q_d;
   logic            out_err_q, out_err_d;
   logic            out_valid_q, out_valid_d;
   logic [ERRW-1:0] err_count_q, err_count_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_mode_d  = alu_mode_q;
      out_q_d     = out_q_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      err_count_d = err_count_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               alu_a_d    = pack_operand(in_mode_fp, in_a);
               alu_b_d    = pack_operand(in_mode_fp, in_b);
               alu_op_d   = in_op;
               alu_mode_d = in_mode_fp;
               cnt_d      = '0;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            // A ready seen on the timeout edge still counts as a clean completion.
            if (alu_ready) begin
               out_q_d     = unpack_result(alu_mode_q, alu_q);
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else if (cnt_q == WAIT_LAST) begin
               out_q_d     = unpack_result(alu_mode_q, alu_q);
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERRW'(1);
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_mode_q  <= 1'b0;
         out_q_q     <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_mode_q  <= alu_mode_d;
         out_q_q     <= out_q_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
         err_count_q <= err_count_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE) && !rst;
   assign busy        = (state_q != S_IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign alu_mode_fp = alu_mode_q;
   assign out_q       = out_q_q;
   assign out_err     = out_err_q;
   assign out_valid   = out_valid_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_strokie_issue_ctrl.sv
// Directed bench for strokie_issue_ctrl; the ALU is a stub driven from the bench.
module tb_strokie_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0;
   logic [1:0]  in_op = '0;
   logic        in_mode_fp = 1'b0;
   logic [31:0] alu_a, alu_b;
   logic [1:0]  alu_op;
   logic        alu_mode_fp;
   logic [31:0] alu_q = '0;
   logic        alu_ready = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_q;
   logic        out_err;
   logic        busy;
   logic [7:0]  err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_errs = 0;

   always #5 clk = ~clk;

   strokie_issue_ctrl #(.SETTLE_CYC(2), .TIMEOUT(16), .ERRW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode_fp(in_mode_fp),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode_fp(alu_mode_fp),
      .alu_q(alu_q), .alu_ready(alu_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_err(out_err),
      .busy(busy), .err_count(err_count)
   );

   typedef struct {
      logic [31:0] a, b;
      logic [1:0]  op;
      logic        mode;
      logic [31:0] resp;
      int          rdy_from, rdy_to;   // edges after accept where the stub drives alu_ready=1
      logic [31:0] exp_alu_a, exp_alu_b, exp_q;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];
   vec_t tov;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_op(input vec_t v);
      int lat;
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_a = v.a; in_b = v.b; in_op = v.op; in_mode_fp = v.mode;
      alu_q = v.resp; alu_ready = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
      chk("alu_a_pack", alu_a, v.exp_alu_a);
      chk("alu_b_pack", alu_b, v.exp_alu_b);
      chk("alu_op_fwd", 32'(alu_op), 32'(v.op));
      chk("alu_mode_fwd", 32'(alu_mode_fp), 32'(v.mode));
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         alu_ready = (k >= v.rdy_from) && (k <= v.rdy_to);
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", 32'(lat), 32'(v.exp_lat));
      chk("out_q", out_q, v.exp_q);
      chk("out_err", 32'(out_err), 32'(v.exp_err));
      chk("alu_a_held", alu_a, v.exp_alu_a);
      if (v.exp_err && exp_errs < 255) exp_errs++;
      chk("err_count", 32'(err_count), 32'(exp_errs));
      @(negedge clk);
      alu_ready = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int cnt;
      vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 2'b00, 1'b1, 32'h4040_0000, 1, 999,
                  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 3};
      vecs[1] = '{32'h0000_3C00, 32'h0000_4000, 2'b00, 1'b0, 32'h4200_ABCD, 1, 999,
                  32'h3C00_0000, 32'h4000_0000, 32'h0000_4200, 1'b0, 3};
      vecs[2] = '{32'hDEAD_3C00, 32'hBEEF_C000, 2'b11, 1'b0, 32'h5555_0000, 1, 999,
                  32'h3C00_0000, 32'hC000_0000, 32'h0000_5555, 1'b0, 3};
      vecs[3] = '{32'h1111_1111, 32'h2222_2222, 2'b01, 1'b1, 32'h0BAD_F00D, 999, 999,
                  32'h1111_1111, 32'h2222_2222, 32'h0BAD_F00D, 1'b1, 18};
      vecs[4] = '{32'h4080_0000, 32'h3F00_0000, 2'b10, 1'b1, 32'h4100_0000, 1, 3,
                  32'h4080_0000, 32'h3F00_0000, 32'h4100_0000, 1'b0, 3};
      vecs[5] = '{32'h0000_7BFF, 32'h0000_0001, 2'b00, 1'b0, 32'h1234_5678, 1, 2,
                  32'h7BFF_0000, 32'h0001_0000, 32'h0000_1234, 1'b1, 18};
      vecs[6] = '{32'hC000_0000, 32'h4000_0000, 2'b00, 1'b1, 32'h0000_0000, 18, 999,
                  32'hC000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 18};
      vecs[7] = '{32'h0000_C400, 32'h0000_3800, 2'b01, 1'b0, 32'hC300_FFFF, 5, 999,
                  32'hC400_0000, 32'h3800_0000, 32'h0000_C300, 1'b0, 5};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_q", out_q, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) do_op(vecs[i]);

      // Backpressure: DONE held with out_ready low, new requests ignored
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h40A0_0000; in_b = 32'h40A0_0000; in_op = 2'b00;
      in_mode_fp = 1'b1; alu_q = 32'h4120_0000; alu_ready = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 10) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("bp_reach_done", 32'(out_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = k[0]; in_a = $urandom; alu_q = $urandom; alu_ready = k[1];
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_q", out_q, 32'h4120_0000);
         chk("bp_out_err", 32'(out_err), 32'd0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_alu_a", alu_a, 32'h40A0_0000);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_busy", 32'(busy), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("bp_not_queued", 32'(busy), 32'd0);

      // Back-to-back throughput: one op every SETTLE_CYC+3 = 5 cycles
      @(negedge clk);
      in_valid = 1'b1; alu_ready = 1'b1; out_ready = 1'b1; alu_q = 32'h3F80_0000;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      @(negedge clk);
      in_valid = 1'b0; alu_ready = 1'b0; out_ready = 1'b0;
      chk("throughput", 32'(cnt), 32'd4);
      @(posedge clk); #1;
      chk("throughput_idle", 32'(busy), 32'd0);

      // Reset during WAIT
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h4248_0000; in_b = 32'h3F80_0000; in_mode_fp = 1'b1;
      alu_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_alu_a", alu_a, 32'h4248_0000);
      chk("mid_err_count", 32'(err_count), 32'(exp_errs));
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_alu_a", alu_a, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_errs = 0;
      do_op(vecs[0]);

      // Saturating error counter
      tov = vecs[3];
      for (int i = 0; i < 256; i++) do_op(tov);
      chk("err_count_sat", 32'(err_count), 32'h0000_00FF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
